// File: rtl/shift_add_mul_ctrl.sv
// Sequencing controller for an N-bit unsigned shift-add multiplier datapath.
// Takes one operand pair per valid/ready handshake, walks the datapath through
// load / add / shift steps driven by the accumulator LSB, then presents the
// 2N-bit product over a second valid/ready handshake.
//
// Optional feature macro: SAM_CTRL_ZERO_BYPASS_EN
//   When defined, a zero operand skips the datapath and jumps straight to DONE
//   with a forced-zero result.

module shift_add_mul_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     mplier_i,
    input  logic [N-1:0]     mcand_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2*N-1:0]   result_o,
    output logic             busy_o,
    output logic             load_o,
    output logic             sh_o,
    output logic             ad_o,
    output logic [N-1:0]     dp_mplier_o,
    output logic [N-1:0]     dp_mcand_o,
    input  logic             m_i,
    input  logic [2*N-1:0]   product_i
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     mplier_q, mcand_q;
    logic             in_ready_q, busy_q, load_q, out_valid_q;
    logic             cnt_last;
    logic             accept;

`ifdef SAM_CTRL_ZERO_BYPASS_EN
    logic zero_q, zero_d;
    logic in_zero;
    assign in_zero = (mplier_i == '0) || (mcand_i == '0);
`endif

    assign cnt_last = (cnt_q == CNT_W'(N - 1));
    assign accept   = (state_q == StIdle) && in_valid_i;

    // Next-state and bit-counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef SAM_CTRL_ZERO_BYPASS_EN
        zero_d  = zero_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
`ifdef SAM_CTRL_ZERO_BYPASS_EN
                    if (in_zero) begin
                        state_d = StDone;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
`else
                    state_d = StLoad;
`endif
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StCheck;
            end
            StCheck: begin
                if (m_i) begin
                    // Add this cycle, the matching shift follows in StShift.
                    state_d = StShift;
                end else if (cnt_last) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (cnt_last) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StCheck;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
`ifdef SAM_CTRL_ZERO_BYPASS_EN
                    zero_d  = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter, operand capture and registered state-decoded outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mplier_q    <= '0;
            mcand_q     <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SAM_CTRL_ZERO_BYPASS_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                mplier_q <= mplier_i;
                mcand_q  <= mcand_i;
            end
            in_ready_q  <= (state_d == StIdle);
            busy_q      <= (state_d != StIdle);
            load_q      <= (state_d == StLoad);
            out_valid_q <= (state_d == StDone);
`ifdef SAM_CTRL_ZERO_BYPASS_EN
            zero_q      <= zero_d;
`endif
        end
    end

    // Add/shift strobes are Mealy on m_i in StCheck, so they stay combinational.
    always_comb begin
        ad_o = (state_q == StCheck) && m_i;
        sh_o = ((state_q == StCheck) && !m_i) || (state_q == StShift);
    end

    // Result is forced to zero whenever it is not being presented.
    always_comb begin
        result_o = '0;
        if (out_valid_q) begin
`ifdef SAM_CTRL_ZERO_BYPASS_EN
            result_o = zero_q ? '0 : product_i;
`else
            result_o = product_i;
`endif
        end
    end

    assign in_ready_o  = in_ready_q;
    assign busy_o      = busy_q;
    assign load_o      = load_q;
    assign out_valid_o = out_valid_q;
    assign dp_mplier_o = mplier_q;
    assign dp_mcand_o  = mcand_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Testbench for shift_add_mul_ctrl with a behavioural shift-add datapath.
// Driver pushes the expected response into a scoreboard queue on each accepted
// operand pair; an independent monitor pops and compares on output handshakes.

module tb_shift_add_mul_ctrl;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [N-1:0]   mplier_i = '0;
    logic [N-1:0]   mcand_i = '0;
    logic           out_valid_o;
    logic           out_ready_i = 1'b1;
    logic [2*N-1:0] result_o;
    logic           busy_o, load_o, sh_o, ad_o;
    logic [N-1:0]   dp_mplier_o, dp_mcand_o;
    logic           m_i;
    logic [2*N-1:0] product_i;

    shift_add_mul_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mplier_i    (mplier_i),
        .mcand_i     (mcand_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o),
        .load_o      (load_o),
        .sh_o        (sh_o),
        .ad_o        (ad_o),
        .dp_mplier_o (dp_mplier_o),
        .dp_mcand_o  (dp_mcand_o),
        .m_i         (m_i),
        .product_i   (product_i)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: acc has a carry bit, q holds the multiplier.
    logic [N:0]   acc;
    logic [N-1:0] q, mc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0; q <= '0; mc <= '0;
        end else if (load_o) begin
            acc <= '0; q <= dp_mplier_o; mc <= dp_mcand_o;
        end else if (ad_o) begin
            acc <= acc + {1'b0, mc};
        end else if (sh_o) begin
            {acc, q} <= {acc, q} >> 1;
        end
    end
    assign m_i       = q[0];
    assign product_i = {acc[N-1:0], q};

    typedef struct {
        logic [2*N-1:0] res;
        int             lat;
        int             ad;
        int             sh;
        int             ld;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Random backpressure when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
    end

    // Monitor: strobe exclusivity, latency, strobe counts, result on handshake.
    initial begin
        int  n_ad = 0, n_sh = 0, n_ld = 0, accept_cyc = 0;
        bit  prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                chk("strobe_onehot", 64'(int'(load_o) + int'(sh_o) + int'(ad_o) <= 1), 64'd1);
                n_ad += int'(ad_o); n_sh += int'(sh_o); n_ld += int'(load_o);
                if (in_valid_i && in_ready_o) begin
                    accept_cyc = cyc; n_ad = 0; n_sh = 0; n_ld = 0;
                end
                if (!out_valid_o) begin
                    if (result_o !== '0) chk("result_zero_when_idle", 64'(result_o), 64'd0);
                end else if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    if (!prev_valid) begin
                        chk("latency", 64'(cyc - accept_cyc), 64'(sb[0].lat));
                        chk("ad_count", 64'(n_ad), 64'(sb[0].ad));
                        chk("sh_count", 64'(n_sh), 64'(sb[0].sh));
                        chk("load_count", 64'(n_ld), 64'(sb[0].ld));
                    end
                    chk("result", 64'(result_o), 64'(sb[0].res));
                    if (out_ready_i) void'(sb.pop_front());
                end
                prev_valid = out_valid_o;
            end
        end
    end

    function automatic exp_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [2*N-1:0] res, input int lat);
        exp_t e;
        e.res = res; e.lat = lat;
        e.ad = $countones(a); e.sh = N; e.ld = 1;
`ifdef SAM_CTRL_ZERO_BYPASS_EN
        if (a == '0 || b == '0) begin
            e.ad = 0; e.sh = 0; e.ld = 0;
        end
`endif
        return e;
    endfunction

    // Present an operand pair, wait for acceptance, push the expectation.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] res, input int lat);
        int t = 0;
        @(posedge clk); #1;
        in_valid_i = 1'b1; mplier_i = a; mcand_i = b;
        @(negedge clk);
        while (!in_ready_o && t < 200) begin @(negedge clk); t++; end
        if (!in_ready_o) chk("accept_timeout", 64'd0, 64'd1);
        else sb.push_back(mk(a, b, res, lat));
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!(sb.size() == 0 && in_ready_o) && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) chk("done_timeout", 64'(sb.size()), 64'd0);
    endtask

`ifdef SAM_CTRL_ZERO_BYPASS_EN
    localparam int LAT_0X9 = 1;
    localparam int LAT_9X0 = 1;
`else
    localparam int LAT_0X9 = 6;
    localparam int LAT_9X0 = 8;
`endif

    initial begin
        int t;
        logic [N-1:0] a, b;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_strobes", 64'({load_o, sh_o, ad_o}), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_dp_ops", 64'({dp_mplier_o, dp_mcand_o}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed vectors with hand-computed products and latencies.
        issue(4'd11, 4'd13, 8'd143, 9);  wait_idle();
        issue(4'd15, 4'd15, 8'd225, 10); wait_idle();
        issue(4'd0,  4'd9,  8'd0,   LAT_0X9); wait_idle();
        issue(4'd9,  4'd0,  8'd0,   LAT_9X0); wait_idle();
        issue(4'd1,  4'd1,  8'd1,   7);  wait_idle();
        issue(4'd8,  4'd15, 8'd120, 7);  wait_idle();

        // Backpressure: hold the result for 5 cycles while poking in_valid.
        out_ready_i = 1'b0;
        issue(4'd15, 4'd15, 8'd225, 10);
        t = 0;
        @(negedge clk);
        while (!out_valid_o && t < 50) begin @(negedge clk); t++; end
        chk("bp_reach_done", 64'(out_valid_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid_i = 1'b1; mplier_i = 4'd9; mcand_i = 4'd9;
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
            chk("bp_out_valid_held", 64'(out_valid_o), 64'd1);
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        wait_idle();

        // Reset during SHIFT: the cycle after the first add is a shift step.
        issue(4'd15, 4'd15, 8'd225, 10);
        t = 0;
        @(negedge clk);
        while (!ad_o && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        chk("pre_reset_in_shift", 64'({sh_o, ad_o}), 64'b10);
        rst_n = 1'b0;
        #1;
        chk("midop_rst_busy", 64'(busy_o), 64'd0);
        chk("midop_rst_in_ready", 64'(in_ready_o), 64'd1);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        issue(4'd3, 4'd5, 8'd15, 8); wait_idle();

        // Random operands under random output stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int lat;
            a = N'($urandom_range(0, (1 << N) - 1));
            b = N'($urandom_range(0, (1 << N) - 1));
            lat = 2 + N + $countones(a);
`ifdef SAM_CTRL_ZERO_BYPASS_EN
            if (a == '0 || b == '0) lat = 1;
`endif
            issue(a, b, {{N{1'b0}}, a} * {{N{1'b0}}, b}, lat);
        end
        @(posedge clk); #1;
        rand_ready = 1'b0; out_ready_i = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
